// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/key type, Rcon, forward S-box and
// GF(2^8) helpers used by both the encrypt and decrypt datapaths.
package aes_pkg;

  typedef logic [15:0][7:0] block_t;  // [15] = FIPS-197 byte 0
  typedef logic [31:0]      word_t;

  typedef enum logic [2:0] {NOKEY, KEYEXP, IDLE, ROUND, HOLD} fsm_t;

  // Indexed by round number 1..10; padded so any 4-bit index stays in range.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // SubWord(RotWord(w)); w[31:24] is the first byte of the word
  function automatic word_t sub_rot_word(input word_t w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  // Row r rotates right by r; FIPS byte n lives at packed index 15-n
  function automatic block_t inv_shift_rows(input block_t b);
    return {b[15], b[2],  b[5],  b[8],
            b[11], b[14], b[1],  b[4],
            b[7],  b[10], b[13], b[0],
            b[3],  b[6],  b[9],  b[12]};
  endfunction

  function automatic word_t inv_mix_word(input word_t w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic block_t inv_mix_columns(input block_t b);
    return {inv_mix_word(b[15:12]), inv_mix_word(b[11:8]),
            inv_mix_word(b[7:4]),   inv_mix_word(b[3:0])};
  endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// Key, ciphertext and plaintext valid/ready channels of the AES-128 decryptor.
interface aes_decrypt_if;
  import aes_pkg::*;

  logic   key_valid;
  block_t key;
  logic   key_ready;
  logic   in_valid;
  block_t state;
  logic   in_ready;
  logic   out_valid;
  logic   out_ready;
  block_t out;

  modport master (
    output key_valid, key, in_valid, state, out_ready,
    input  key_ready, in_ready, out_valid, out
  );

  modport slave (
    input  key_valid, key, in_valid, state, out_ready,
    output key_ready, in_ready, out_valid, out
  );
endinterface

// File: rtl/inv_sbox.sv
// AES inverse S-box: 256-entry combinational lookup.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign y = TBL[a];
endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher: one round per cycle, round keys derived
// on the fly backwards from the retained last round key.
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  aes_decrypt_if.slave bus
);

  fsm_t       fsm, fsm_nxt;
  logic [3:0] rnd;          // KEYEXP: round key being made (1..10); ROUND: key being applied (9..0)
  block_t     rk10;         // retained last round key, reused for every block
  block_t     rk;           // working round key, walks backwards during ROUND
  block_t     s;            // cipher state
  block_t     out_q;
  logic       key_open, ct_open, take_key, take_ct;

  // Key schedule: one shared SubWord(RotWord) serves both directions since
  // KEYEXP and ROUND never overlap.
  word_t      kw0, kw1, kw2, kw3, rw0, rw1, rw2, rw3;
  word_t      f0, f1, f2, f3, p0, p1, p2, p3;
  word_t      sw_in, sw, rc_word;
  logic [3:0] rc_idx;
  block_t     rk_fwd, rk_prev, isr, isb, ark, s_nxt;

  assign {kw0, kw1, kw2, kw3} = rk10;
  assign {rw0, rw1, rw2, rw3} = rk;

  // Going backwards from key i, the previous key's last word is w3^w2 and
  // Rcon is that of round i.
  assign rc_idx  = (fsm == KEYEXP) ? rnd : rnd + 4'd1;
  assign rc_word = {RCON[rc_idx], 24'h000000};
  assign sw_in   = (fsm == KEYEXP) ? kw3 : (rw3 ^ rw2);
  assign sw      = sub_rot_word(sw_in);

  assign f0 = kw0 ^ sw ^ rc_word;
  assign f1 = kw1 ^ f0;
  assign f2 = kw2 ^ f1;
  assign f3 = kw3 ^ f2;
  assign rk_fwd = {f0, f1, f2, f3};

  assign p3 = rw3 ^ rw2;
  assign p2 = rw2 ^ rw1;
  assign p1 = rw1 ^ rw0;
  assign p0 = rw0 ^ sw ^ rc_word;
  assign rk_prev = {p0, p1, p2, p3};

  // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
  assign isr = inv_shift_rows(s);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_sbox u_isb (.a(isr[i]), .y(isb[i]));
  end

  assign ark   = isb ^ rk_prev;
  assign s_nxt = (rnd == 4'd0) ? ark : inv_mix_columns(ark);

  // Handshake outputs
  assign bus.key_ready = key_open;
  assign bus.in_ready  = ct_open;
  assign bus.out_valid = (fsm == HOLD);
  assign bus.out       = out_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) fsm <= NOKEY;
    else        fsm <= fsm_nxt;
  end

  // Next state and channel readiness; a key offer always pre-empts ciphertext
  always_comb begin
    fsm_nxt  = fsm;
    key_open = 1'b0;
    ct_open  = 1'b0;
    take_key = 1'b0;
    take_ct  = 1'b0;
    unique case (fsm)
      NOKEY: begin
        key_open = 1'b1;
        if (bus.key_valid) begin
          take_key = 1'b1;
          fsm_nxt  = KEYEXP;
        end
      end
      KEYEXP: if (rnd == 4'd10) fsm_nxt = IDLE;
      IDLE: begin
        key_open = 1'b1;
        ct_open  = !bus.key_valid;
        if (bus.key_valid) begin
          take_key = 1'b1;
          fsm_nxt  = KEYEXP;
        end else if (bus.in_valid) begin
          take_ct = 1'b1;
          fsm_nxt = ROUND;
        end
      end
      ROUND: if (rnd == 4'd0) fsm_nxt = HOLD;
      HOLD:  if (bus.out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = NOKEY;
    endcase
  end

  // Key, state, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd   <= 4'd0;
      rk10  <= '0;
      rk    <= '0;
      s     <= '0;
      out_q <= '0;
    end else begin
      unique case (fsm)
        NOKEY, IDLE: begin
          if (take_key) begin
            rk10 <= bus.key;
            rnd  <= 4'd1;
          end else if (take_ct) begin
            s   <= bus.state ^ rk10;
            rk  <= rk10;
            rnd <= 4'd9;
          end
        end
        KEYEXP: begin
          rk10 <= rk_fwd;
          rnd  <= (rnd == 4'd10) ? 4'd0 : rnd + 4'd1;
        end
        ROUND: begin
          rk <= rk_prev;
          s  <= s_nxt;
          if (rnd == 4'd0) out_q <= s_nxt;
          else             rnd   <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed + randomized bench for aes_decrypt. Expected plaintexts come from
// a forward AES-128 cipher model whose S-box is generated from GF(2^8)
// inversion plus the affine map.
module tb_aes_decrypt;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  logic [7:0] sb [256];

  localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt_if bus ();

  aes_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int e = 0; e < 254; e++) v = gm(v, x);  // x^254 = x^-1, 0 -> 0
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // Forward AES-128 encryption; also returns round key 10
  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt,
                                       output logic [127:0] k10);
    logic [7:0] rk [11][16];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] acc;
    for (int n = 0; n < 16; n++) rk[0][n] = 8'(key >> (8 * (15 - n)));
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk[r][0] = rk[r-1][0] ^ sb[rk[r-1][13]] ^ rc;
      rk[r][1] = rk[r-1][1] ^ sb[rk[r-1][14]];
      rk[r][2] = rk[r-1][2] ^ sb[rk[r-1][15]];
      rk[r][3] = rk[r-1][3] ^ sb[rk[r-1][12]];
      for (int n = 4; n < 16; n++) rk[r][n] = rk[r-1][n] ^ rk[r][n-4];
      rc = xt(rc);
    end
    for (int n = 0; n < 16; n++) s[n] = 8'(pt >> (8 * (15 - n))) ^ rk[0][n];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w + 4*c] = t[w + 4*((c + w) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[r][n];
    end
    acc = '0;
    for (int n = 0; n < 16; n++) acc = (acc << 8) | 128'(rk[10][n]);
    k10 = acc;
    acc = '0;
    for (int n = 0; n < 16; n++) acc = (acc << 8) | 128'(s[n]);
    return acc;
  endfunction

  // ---------------- checking / driving helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Entered and left at negedge+1; returns with the key schedule finished
  task automatic load_key(input logic [127:0] k, input string tag);
    int n;
    n = 0;
    while (!bus.key_ready && n < 100) begin @(negedge clk); #1; n++; end
    bus.key_valid = 1'b1;
    bus.key       = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
    #1;
    chk({tag, " key_ready during KEYEXP"}, 128'(bus.key_ready), 128'd0);
    n = 0;
    while (!bus.key_ready && n < 40) begin @(negedge clk); #1; n++; end
    chk({tag, " KEYEXP cycles"}, 128'(n), 128'd10);
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] expv,
                           input int stall, input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); #1; n++; end
    bus.in_valid = 1'b1;
    bus.state    = ct;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); #1; n++; end
    chk({tag, " latency"}, 128'(n), 128'd10);
    chk({tag, " out"}, bus.out, expv);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      chk({tag, " stall out_valid"}, 128'(bus.out_valid), 128'd1);
      chk({tag, " stall out"}, bus.out, expv);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk({tag, " out_valid after accept"}, 128'(bus.out_valid), 128'd0);
    chk({tag, " out held in IDLE"}, bus.out, expv);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k, pt, ct, k10;
    int n;

    for (int x = 0; x < 256; x++) sb[x] = sbox_byte(8'(x));

    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.in_valid  = 1'b0;
    bus.state     = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset key_ready", 128'(bus.key_ready), 128'd1);
    chk("reset in_ready", 128'(bus.in_ready), 128'd0);
    chk("reset out_valid", 128'(bus.out_valid), 128'd0);
    chk("reset out", bus.out, 128'd0);
    rst_n = 1'b1;

    // ciphertext without a key is ignored
    bus.in_valid = 1'b1;
    bus.state    = CT1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("nokey in_ready", 128'(bus.in_ready), 128'd0);
      chk("nokey out_valid", 128'(bus.out_valid), 128'd0);
    end
    bus.in_valid = 1'b0;

    // FIPS-197 C.1
    load_key(K1, "c1");
    chk("c1 rk10", dut.rk10, RK10A);
    run_block(CT1, PT1, 0, "c1");

    // key and ciphertext together in IDLE: key wins
    bus.key_valid = 1'b1;
    bus.key       = K2;
    bus.in_valid  = 1'b1;
    bus.state     = CT1;
    #1;
    chk("collide in_ready", 128'(bus.in_ready), 128'd0);
    chk("collide key_ready", 128'(bus.key_ready), 128'd1);
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    n = 0;
    while (!bus.key_ready && n < 40) begin @(negedge clk); #1; n++; end
    chk("collide KEYEXP cycles", 128'(n), 128'd10);
    chk("collide out_valid", 128'(bus.out_valid), 128'd0);
    chk("collide in_ready after KEYEXP", 128'(bus.in_ready), 128'd1);

    // FIPS-197 appendix B with the key just loaded
    run_block(CT2, PT2, 2, "b");

    // two back-to-back blocks, one key load, 5-cycle output stall
    load_key(K1, "b2b");
    bus.in_valid = 1'b1;
    bus.state    = CT1;
    @(negedge clk); #1;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      chk("b2b in_ready busy", 128'(bus.in_ready), 128'd0);
      @(negedge clk); #1;
      n++;
    end
    chk("b2b first latency", 128'(n), 128'd10);
    chk("b2b first out", bus.out, PT1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("b2b stall out_valid", 128'(bus.out_valid), 128'd1);
      chk("b2b stall out", bus.out, PT1);
      chk("b2b stall in_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("b2b out_valid after take", 128'(bus.out_valid), 128'd0);
    chk("b2b in_ready after take", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); #1; n++; end
    chk("b2b second latency", 128'(n), 128'd10);
    chk("b2b second out", bus.out, PT1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;

    // reset in the middle of ROUND
    bus.in_valid = 1'b1;
    bus.state    = CT1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midreset out_valid", 128'(bus.out_valid), 128'd0);
    chk("midreset key_ready", 128'(bus.key_ready), 128'd1);
    chk("midreset in_ready", 128'(bus.in_ready), 128'd0);
    chk("midreset out", bus.out, 128'd0);
    chk("midreset rk10", dut.rk10, 128'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      chk("postreset in_ready", 128'(bus.in_ready), 128'd0);
      chk("postreset out_valid", 128'(bus.out_valid), 128'd0);
    end
    bus.in_valid = 1'b0;
    load_key(K1, "reload");
    run_block(CT1, PT1, 0, "reload");

    // random keys and plaintexts against the forward-cipher model
    for (int kk = 0; kk < 6; kk++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k, "rnd");
      ct = enc(k, 128'd0, k10);
      chk("rnd rk10", dut.rk10, k10);
      for (int j = 0; j < 3; j++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = enc(k, pt, k10);
        run_block(ct, pt, int'($urandom_range(0, 3)), "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, Nr fixed at 10.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 key_valid  in  1  cipher key offered.
REQ-005 key  in  [15:0][7:0]  cipher key; key[15] = FIPS-197 byte k0 (bits 127:120).
REQ-006 key_ready  out  1  block can accept a key.
REQ-007 in_valid  in  1  ciphertext offered.
REQ-008 state  in  [15:0][7:0]  ciphertext; state[15] = FIPS-197 in0; column-major byte order.
REQ-009 in_ready  out  1  block can accept ciphertext.
REQ-010 out_valid  out  1  plaintext valid.
REQ-011 out_ready  in  1  consumer accepts plaintext.
REQ-012 out  out  [15:0][7:0]  plaintext, same byte order as state.

Function
REQ-013 The block SHALL use an FSM with states NOKEY, KEYEXP, IDLE, ROUND and HOLD.
REQ-014 A transfer SHALL occur on any edge where valid and ready are both high; ready SHALL never depend on valid of the same channel, except as stated in REQ-016.
REQ-015 key_ready SHALL be 1 in NOKEY and IDLE and 0 otherwise; a key transfer SHALL go to KEYEXP.
REQ-016 in_ready SHALL be (FSM==IDLE && !key_valid); when key and ciphertext are offered together, the key wins.
REQ-017 KEYEXP SHALL run the forward key schedule one round key per cycle for exactly 10 cycles, retain only round key 10, then go to IDLE.
REQ-018 A ciphertext transfer SHALL load s = state ^ rk10 and rk = rk10, then go to ROUND with round counter = 9.
REQ-019 Each ROUND cycle SHALL derive the previous round key from rk by inverse key expansion (Rcon by counter) and apply InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns; the final round (key 0) SHALL skip InvMixColumns.
REQ-020 After 10 ROUND cycles the block SHALL enter HOLD with out = plaintext and out_valid = 1; the accept edge to out_valid high SHALL be exactly 10 cycles.
REQ-021 In HOLD, out and out_valid SHALL stay stable until out_ready = 1; on that transfer the block SHALL return to IDLE with the key retained.
REQ-022 The retained rk10 SHALL be reused for every following block until a new key transfer occurs.
REQ-023 out SHALL hold its last value outside HOLD; out_valid SHALL be 1 only in HOLD.
REQ-024 in_valid without a key (NOKEY) SHALL be ignored.

Reset
REQ-025 When rst_n = 0 at an edge, the FSM SHALL go to NOKEY with out_valid = 0, out = 0, the stored key cleared and counters cleared; this SHALL abort any in-progress KEYEXP or ROUND.
REQ-026 After reset, key_ready SHALL be 1 and in_ready SHALL be 0.

Structure
REQ-027 A shared package aes_pkg SHALL hold the block/key typedef ([15:0][7:0]), the Rcon table and the GF(2^8) xtime/multiply functions; these are shared with the encrypt path.
REQ-028 The inverse S-box SHALL be a separate sub-module inv_sbox (256-entry combinational lookup), instantiated 16 times for the state; the forward sbox SHALL be reused for key expansion.

Verification
REQ-029 Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff, 10 cycles after accept; internal rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734.
REQ-031 Two back-to-back C.1 ciphertexts with one key load, out_ready held 0 for 5 cycles -> out stable through the stall; in_ready = 0 until the first block is taken; both outputs correct.
REQ-032 key_valid and in_valid both high in IDLE -> key accepted, ciphertext not accepted (in_ready = 0), KEYEXP lasts 10 cycles.
REQ-033 rst_n pulsed low mid-ROUND -> next cycle out_valid = 0, key_ready = 1, in_ready = 0; in_valid is ignored until a key is reloaded.
REQ-034 in_valid high in NOKEY for 20 cycles -> no transfer, out_valid stays 0.
